// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the hidden-layer datapath: activation/RAM word width,
// RAM address width, and the state encoding of the hidden-unit RAM sequencer.
// The MAC, the hidden-unit RAM and the sequencer all import this package so
// their widths cannot drift apart.
// ---------------------------------------------------------------------------
package snn_pkg;

    // Activation width; also the hidden-unit RAM word width.
    localparam int DATA_WIDTH = 8;
    // Hidden-unit RAM address width (32 entries).
    localparam int ADDR_WIDTH = 5;

    // Sequencer state encoding. Kept as plain constants so other blocks
    // (debug taps, status registers) can decode the state without the enum.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_PRIME = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FILL  = ST_FILL,
        S_PRIME = ST_PRIME,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } seq_state_t;

    // Index of the last entry used for a layer of n units. n is expected to
    // be in 1..2**ADDR_WIDTH, so the result always fits the address width.
    function automatic logic [ADDR_WIDTH-1:0] last_index(input int n);
        return ADDR_WIDTH'(n - 1);
    endfunction

endpackage

// File: rtl/hidden_ram_seq_if.sv
// ---------------------------------------------------------------------------
// hidden_ram_seq_if
// Bundles the three buses the hidden-unit RAM sequencer sits between:
//   write side  : wr_valid / wr_data from the hidden MAC, wr_ready back
//   read side   : rd_valid / rd_data to the output-layer MAC, rd_ready back
//   RAM side    : ram_addr / ram_we / ram_data to the RAM, ram_q from it
// Modports:
//   master : the sequencer (drives ready/valid towards the MACs and the RAM
//            control lines)
//   slave  : the surrounding layer (MACs plus RAM)
// ---------------------------------------------------------------------------
interface hidden_ram_seq_if;
    import snn_pkg::*;

    // Hidden MAC -> sequencer
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;

    // Sequencer -> output-layer MAC
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;

    // Sequencer <-> hidden-unit RAM
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] ram_q;

    modport master (
        input  wr_valid, wr_data, rd_ready, ram_q,
        output wr_ready, rd_valid, rd_data, ram_addr, ram_we, ram_data
    );

    modport slave (
        output wr_valid, wr_data, rd_ready, ram_q,
        input  wr_ready, rd_valid, rd_data, ram_addr, ram_we, ram_data
    );

endinterface

// File: rtl/hidden_ram_seq.sv
// ---------------------------------------------------------------------------
// hidden_ram_seq
// Sequencer for the 32x8 hidden-unit RAM (synchronous write, registered read
// address, one-cycle read latency).
//   FILL  : accepts NUM_UNITS activations from the hidden MAC and writes them
//           to addresses 0..NUM_UNITS-1.
//   DRAIN : streams them back in address order to the output-layer MAC with
//           valid/ready backpressure.
//   REPLAY: re-runs DRAIN on the stored layer without refilling.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   pulse, FILL then DRAIN; only looked at in IDLE
//   replay  in   pulse, DRAIN only; only looked at in IDLE with loaded=1
//   busy    out  state != IDLE
//   loaded  out  a complete FILL has finished since reset
//   done    out  one-cycle pulse after the last DRAIN handshake
//   bus     if   master side of hidden_ram_seq_if (write, read, RAM buses)
//
// Parameters:
//   NUM_UNITS  entries used per layer, legal range 1..2**ADDR_WIDTH
// ---------------------------------------------------------------------------
module hidden_ram_seq
    import snn_pkg::*;
#(
    parameter int NUM_UNITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               replay,
    output logic               busy,
    output logic               loaded,
    output logic               done,
    hidden_ram_seq_if.master   bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = last_index(NUM_UNITS);

    // ---------------------------------------------------------------------
    // State and counters
    // ---------------------------------------------------------------------
    seq_state_t            state_reg;
    seq_state_t            state_next;
    logic [ADDR_WIDTH-1:0] wr_idx_reg;
    logic [ADDR_WIDTH-1:0] wr_idx_next;
    logic [ADDR_WIDTH-1:0] rd_idx_reg;
    logic [ADDR_WIDTH-1:0] rd_idx_next;
    logic                  loaded_reg;
    logic                  loaded_next;

    // Combinational outputs, gathered here before driving the interface.
    logic                  wr_ready_c;
    logic                  rd_valid_c;
    logic                  ram_we_c;
    logic [ADDR_WIDTH-1:0] ram_addr_c;
    logic [DATA_WIDTH-1:0] ram_data_c;
    logic                  done_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            loaded_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
            loaded_reg <= loaded_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        rd_idx_next = rd_idx_reg;
        loaded_next = loaded_reg;
        wr_ready_c  = 1'b0;
        rd_valid_c  = 1'b0;
        ram_we_c    = 1'b0;
        ram_addr_c  = '0;
        ram_data_c  = '0;
        done_c      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // start wins over replay; replay needs a stored layer.
                if (start) begin
                    state_next  = S_FILL;
                    wr_idx_next = '0;
                end else if (replay && loaded_reg) begin
                    state_next = S_PRIME;
                end
            end

            S_FILL: begin
                wr_ready_c = 1'b1;
                ram_we_c   = bus.wr_valid;
                ram_data_c = bus.wr_data;
                ram_addr_c = wr_idx_reg;
                // wr_valid low is a stall: nothing written, index held.
                if (bus.wr_valid) begin
                    if (wr_idx_reg == LAST_IDX) begin
                        state_next  = S_PRIME;
                        loaded_next = 1'b1;
                    end else begin
                        wr_idx_next = wr_idx_reg + ADDR_WIDTH'(1);
                    end
                end
            end

            S_PRIME: begin
                // Present address 0 one cycle ahead so ram_q holds entry 0
                // on the first DRAIN cycle.
                ram_addr_c  = '0;
                rd_idx_next = '0;
                state_next  = S_DRAIN;
            end

            S_DRAIN: begin
                rd_valid_c = 1'b1;
                // Look one entry ahead on a handshake; on a stall the same
                // address is re-registered so ram_q stays put. On the final
                // handshake the look-ahead address is never consumed.
                ram_addr_c = rd_idx_reg + ADDR_WIDTH'(bus.rd_ready);
                if (bus.rd_ready) begin
                    if (rd_idx_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        rd_idx_next = rd_idx_reg + ADDR_WIDTH'(1);
                    end
                end
            end

            S_DONE: begin
                done_c     = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Output drive
    // ---------------------------------------------------------------------
    assign bus.wr_ready = wr_ready_c;
    assign bus.rd_valid = rd_valid_c;
    // The RAM already registers its address, so the word is passed through
    // without another register stage.
    assign bus.rd_data  = bus.ram_q;
    assign bus.ram_we   = ram_we_c;
    assign bus.ram_addr = ram_addr_c;
    assign bus.ram_data = ram_data_c;

    assign busy   = (state_reg != S_IDLE);
    assign loaded = loaded_reg;
    assign done   = done_c;

endmodule

// File: tb/tb_hidden_ram_seq.sv
module tb_hidden_ram_seq;
    import snn_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic replay;
    logic busy;
    logic loaded;
    logic done;

    hidden_ram_seq_if bus ();

    hidden_ram_seq #(.NUM_UNITS(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .replay (replay),
        .busy   (busy),
        .loaded (loaded),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural hidden-unit RAM: synchronous write, registered read address.
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] addr_q;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
        addr_q <= bus.ram_addr;
    end
    assign bus.ram_q = mem[addr_q];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         use_replay;   // 1: replay pulse, 0: start pulse + fill
        bit         inject_start; // pulse start during DRAIN (must be ignored)
        logic [7:0] base;         // fill data = base + index
        int         gap_at;       // words sent before the wr_valid gap (-1: none)
        int         gap_len;      // gap length in cycles
        logic [3:0] rdy_pat;      // rd_ready pattern, bit (drain cycle % 4)
        int         exp_lat;      // cycles from pulse to first rd_valid
        int         exp_writes;   // RAM writes expected
        logic [7:0] exp_first;    // first word read back
        logic [7:0] exp_last;     // last word read back
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int id, input vec_t v);
        int c = 0;
        int sent = 0;
        int gap_cnt = 0;
        int writes = 0;
        int hs = 0;
        int d = 0;
        int lat = -1;
        int phase = 0;
        bit seen = 0;
        bit finished = 0;
        bit in_gap;
        logic [7:0] last_data = 8'h00;
        while (!finished && c < 400) begin
            @(negedge clk);
            start  = (c == 0 && !v.use_replay) || (v.inject_start && seen && d == 5);
            replay = (c == 0 && v.use_replay);
            in_gap = (c >= 1) && (sent == v.gap_at) && (gap_cnt < v.gap_len);
            if (in_gap) gap_cnt++;
            bus.wr_valid = !v.use_replay && (c >= 1) && (sent < N) && !in_gap;
            bus.wr_data  = v.base + 8'(sent);
            bus.rd_ready = v.rdy_pat[d % 4];
            #1;
            if (bus.wr_valid && bus.wr_ready) sent++;
            if (bus.ram_we) begin
                check("wr_addr", 32'(bus.ram_addr), writes);
                check("wr_data", 32'(bus.ram_data), 32'(v.base) + writes);
                writes++;
            end
            if (phase == 1) begin
                check("done_pulse", 32'(done), 1);
                check("done_rd_valid", 32'(bus.rd_valid), 0);
                phase = 2;
            end else if (phase == 2) begin
                check("done_cleared", 32'(done), 0);
                check("idle_busy", 32'(busy), 0);
                finished = 1;
            end else if (done) begin
                check("early_done", 32'(done), 0);
            end
            if (bus.rd_valid) begin
                if (!seen) begin
                    seen = 1;
                    lat = c;
                    check("latency", lat, v.exp_lat);
                end
                check("rd_data", 32'(bus.rd_data), 32'(v.exp_first) + hs);
                if (bus.rd_ready) begin
                    hs++;
                    last_data = bus.rd_data;
                    if (hs == N) phase = 1;
                end
            end
            if (seen) d++;
            c++;
        end
        start = 1'b0;
        replay = 1'b0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("completed", 32'(finished), 1);
        check("handshakes", hs, N);
        check("writes", writes, v.exp_writes);
        check("last_word", 32'(last_data), 32'(v.exp_last));
        check("loaded", 32'(loaded), 1);
        $display("vec %0d: latency %0d, writes %0d, handshakes %0d, last 0x%02h, cycles %0d",
                 id, lat, writes, hs, last_data, c);
    endtask

    initial begin
        int hs;
        rst = 1'b1;
        start = 1'b0;
        replay = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus.rd_ready = 1'b0;

        //             rep  inj  base   gap  len  pat      lat wr  first  last
        vecs[0] = '{1'b0, 1'b0, 8'h00, -1, 0, 4'b1111, 34, 32, 8'h00, 8'h1F};
        vecs[1] = '{1'b0, 1'b0, 8'h00, -1, 0, 4'b0101, 34, 32, 8'h00, 8'h1F};
        vecs[2] = '{1'b1, 1'b0, 8'h00, -1, 0, 4'b1111,  2,  0, 8'h00, 8'h1F};
        vecs[3] = '{1'b0, 1'b0, 8'h40, 11, 5, 4'b1111, 39, 32, 8'h40, 8'h5F};
        vecs[4] = '{1'b1, 1'b1, 8'h00, -1, 0, 4'b0011,  2,  0, 8'h40, 8'h5F};
        vecs[5] = '{1'b0, 1'b0, 8'h80, -1, 0, 4'b1111, 34, 32, 8'h80, 8'h9F};

        // Reset state
        @(negedge clk);
        #1;
        check("rst_wr_ready", 32'(bus.wr_ready), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_ram_addr", 32'(bus.ram_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_loaded", 32'(loaded), 0);
        check("rst_done", 32'(done), 0);
        $display("reset: busy %0b loaded %0b", busy, loaded);
        @(negedge clk);
        rst = 1'b0;

        // Replay with nothing loaded is ignored
        @(negedge clk);
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("replay_unloaded_busy", 32'(busy), 0);
            @(negedge clk);
        end
        $display("replay before fill: busy %0b", busy);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of a replay drain, at index 7
        @(negedge clk);
        replay = 1'b1;
        bus.rd_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 50 && hs < 7; k++) begin
            @(negedge clk);
            replay = 1'b0;
            #1;
            if (bus.rd_valid) hs++;
        end
        check("mid_hs", hs, 7);
        @(negedge clk);
        #1;
        check("mid_rd_valid", 32'(bus.rd_valid), 1);
        check("mid_rd_data", 32'(bus.rd_data), 32'h47);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_rd_valid", 32'(bus.rd_valid), 0);
        check("arst_loaded", 32'(loaded), 0);
        check("arst_ram_we", 32'(bus.ram_we), 0);
        check("arst_done", 32'(done), 0);
        $display("async reset at idx 7: busy %0b loaded %0b", busy, loaded);
        @(negedge clk);
        rst = 1'b0;
        bus.rd_ready = 1'b0;
        @(negedge clk);
        replay = 1'b1;
        @(negedge clk);
        replay = 1'b0;
        #1;
        check("post_rst_replay_busy", 32'(busy), 0);

        run_vec(5, vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
